// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 12;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic {
        NORMAL,
        FORCE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_PER
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles the peripheral waits; flags when the next wait would hit the limit.
module arb_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic per_req,
    input  logic per_ack,
    output logic limit_hit
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || per_ack || !per_req) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Raised in the last waiting cycle so the peripheral is forced in on the next one.
    always_comb begin
        limit_hit = per_req && !per_ack && (count_q == CNT_W'(STARVE_LIMIT - 1));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data RAM between the CPU (fixed priority) and one peripheral
// requester with bounded wait, and steers the synchronous read data back to its issuer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DMEM_ADDR_W,
    parameter int unsigned DATA_W       = DMEM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_en,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,

    input  logic              per_req,
    input  logic              per_wren,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_data,
    output logic              per_ack,
    output logic [DATA_W-1:0] per_q,
    output logic              per_qvalid,

    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    arb_state_t state_q, state_d;
    owner_t     owner;
    owner_t     last_owner_q;
    logic       last_rd_q;
    logic       cur_rd;
    logic       limit_hit;

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .per_req  (per_req),
        .per_ack  (per_ack),
        .limit_hit(limit_hit)
    );

    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            case (state_q)
                NORMAL: begin
                    if (cpu_en) begin
                        owner = OWN_CPU;
                    end else if (per_req) begin
                        owner = OWN_PER;
                    end
                end
                FORCE: begin
                    // A dropped request in FORCE issues nothing; the CPU still loses the slot.
                    if (per_req) begin
                        owner = OWN_PER;
                    end
                end
                default: owner = OWN_NONE;
            endcase
        end
    end

    // FORCE lasts exactly one cycle.
    always_comb begin
        state_d = NORMAL;
        if (!reset && state_q == NORMAL && limit_hit) begin
            state_d = FORCE;
        end
    end

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        cur_rd     = 1'b0;
        case (owner)
            OWN_CPU: begin
                ram_wEn    = cpu_wren;
                ram_addr   = cpu_addr;
                ram_dataIn = cpu_data;
                cur_rd     = !cpu_wren;
            end
            OWN_PER: begin
                ram_wEn    = per_wren;
                ram_addr   = per_addr;
                ram_dataIn = per_data;
                cur_rd     = !per_wren;
            end
            default: begin
                ram_wEn = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= NORMAL;
            last_owner_q <= OWN_NONE;
            last_rd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= owner;
            last_rd_q    <= cur_rd;
        end
    end

    always_comb begin
        per_ack    = (owner == OWN_PER);
        cpu_stall  = reset || (state_q == FORCE && cpu_en);
        cpu_q      = ram_dataOut;
        per_q      = ram_dataOut;
        // Gated by reset so a read in flight when reset rises never reports valid.
        per_qvalid = !reset && (last_owner_q == OWN_PER) && last_rd_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: STARVE_LIMIT=8 instance plus a STARVE_LIMIT=1 instance.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_en, cpu_wren, per_req, per_wren;
    logic [AW-1:0] cpu_addr, per_addr;
    logic [DW-1:0] cpu_data, per_data;

    logic [DW-1:0] cpu_q0, per_q0, ram_dataIn0, ram_dataOut0;
    logic          cpu_stall0, per_ack0, per_qvalid0, ram_wEn0;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] cpu_q1, per_q1, ram_dataIn1, ram_dataOut1;
    logic          cpu_stall1, per_ack1, per_qvalid1, ram_wEn1;
    logic [AW-1:0] ram_addr1;

    logic [DW-1:0] mem0 [0:4095];
    logic [DW-1:0] mem1 [0:4095];
    logic [DW-1:0] exp_pq [$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) u_dut0 (
        .clock(clock), .reset(reset),
        .cpu_en(cpu_en), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q0), .cpu_stall(cpu_stall0),
        .per_req(per_req), .per_wren(per_wren), .per_addr(per_addr), .per_data(per_data),
        .per_ack(per_ack0), .per_q(per_q0), .per_qvalid(per_qvalid0),
        .ram_wEn(ram_wEn0), .ram_addr(ram_addr0), .ram_dataIn(ram_dataIn0),
        .ram_dataOut(ram_dataOut0)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .cpu_en(cpu_en), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q1), .cpu_stall(cpu_stall1),
        .per_req(per_req), .per_wren(per_wren), .per_addr(per_addr), .per_data(per_data),
        .per_ack(per_ack1), .per_q(per_q1), .per_qvalid(per_qvalid1),
        .ram_wEn(ram_wEn1), .ram_addr(ram_addr1), .ram_dataIn(ram_dataIn1),
        .ram_dataOut(ram_dataOut1)
    );

    // Read-first synchronous RAMs.
    always @(posedge clock) begin
        ram_dataOut0 <= mem0[ram_addr0];
        if (ram_wEn0) mem0[ram_addr0] <= ram_dataIn0;
        ram_dataOut1 <= mem1[ram_addr1];
        if (ram_wEn1) mem1[ram_addr1] <= ram_dataIn1;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic idle();
        cpu_en   = 1'b0;
        cpu_wren = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;
        per_req  = 1'b0;
        per_wren = 1'b0;
        per_addr = '0;
        per_data = '0;
    endtask

    // Peripheral read scoreboard for the STARVE_LIMIT=8 instance.
    always @(negedge clock) begin
        if (per_qvalid0 === 1'b1) begin
            if (exp_pq.size() == 0) begin
                chk("pq_unexpected", per_qvalid0, 1'b0);
            end else begin
                chk("per_q", per_q0, exp_pq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[16] = 32'hDEAD_BEEF;
        mem1[16] = 32'hDEAD_BEEF;

        // Reset with active requests on both sides: nothing may issue.
        idle();
        reset    = 1'b1;
        cpu_en   = 1'b1;
        cpu_wren = 1'b1;
        cpu_addr = 12'h030;
        cpu_data = 32'hFFFF_FFFF;
        per_req  = 1'b1;
        per_wren = 1'b1;
        per_addr = 12'h010;
        smp();
        chk("rst_stall", cpu_stall0, 1'b1);
        chk("rst_ack", per_ack0, 1'b0);
        chk("rst_wen", ram_wEn0, 1'b0);
        chk("rst_qvalid", per_qvalid0, 1'b0);
        adv();
        adv();
        reset = 1'b0;
        idle();
        smp();
        chk("idle_stall", cpu_stall0, 1'b0);
        chk("idle_wen", ram_wEn0, 1'b0);
        chk("idle_addr", ram_addr0, 12'h000);
        chk("idle_ack", per_ack0, 1'b0);
        adv();

        // Idle CPU, peripheral read of 0x010.
        per_req  = 1'b1;
        per_wren = 1'b0;
        per_addr = 12'h010;
        smp();
        chk("pr_ack", per_ack0, 1'b1);
        chk("pr_addr", ram_addr0, 12'h010);
        chk("pr_wen", ram_wEn0, 1'b0);
        chk("pr_stall", cpu_stall0, 1'b0);
        exp_pq.push_back(32'hDEAD_BEEF);
        adv();
        idle();
        smp();
        chk("pr_qvalid", per_qvalid0, 1'b1);
        chk("pr_ack_off", per_ack0, 1'b0);
        adv();

        // CPU store collides with peripheral write; CPU wins, then starvation forces the write.
        cpu_en   = 1'b1;
        cpu_wren = 1'b1;
        cpu_addr = 12'h030;
        cpu_data = 32'h5555_AAAA;
        per_req  = 1'b1;
        per_wren = 1'b1;
        per_addr = 12'h020;
        per_data = 32'h0000_1234;
        smp();
        chk("col_wen", ram_wEn0, 1'b1);
        chk("col_addr", ram_addr0, 12'h030);
        chk("col_din", ram_dataIn0, 32'h5555_AAAA);
        chk("col_ack", per_ack0, 1'b0);
        chk("col_stall", cpu_stall0, 1'b0);
        adv();
        cpu_wren = 1'b0;
        cpu_addr = 12'h040;
        for (int i = 2; i <= 8; i++) begin
            smp();
            chk("wait_ack", per_ack0, 1'b0);
            chk("wait_stall", cpu_stall0, 1'b0);
            adv();
        end
        smp();
        chk("force_ack", per_ack0, 1'b1);
        chk("force_stall", cpu_stall0, 1'b1);
        chk("force_wen", ram_wEn0, 1'b1);
        chk("force_addr", ram_addr0, 12'h020);
        chk("force_din", ram_dataIn0, 32'h0000_1234);
        adv();
        per_req  = 1'b0;
        per_wren = 1'b0;
        smp();
        chk("post_stall", cpu_stall0, 1'b0);
        chk("post_ack", per_ack0, 1'b0);
        chk("post_qvalid", per_qvalid0, 1'b0);
        adv();
        cpu_addr = 12'h020;
        smp();
        chk("rd020_stall", cpu_stall0, 1'b0);
        adv();
        cpu_addr = 12'h030;
        smp();
        chk("cpu_q_020", cpu_q0, 32'h0000_1234);
        adv();
        cpu_addr = 12'h040;
        smp();
        chk("cpu_q_030", cpu_q0, 32'h5555_AAAA);
        adv();

        // Request dropped after 5 waits, then re-asserted: full wait restarts.
        per_req  = 1'b1;
        per_addr = 12'h010;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("drop_wait_ack", per_ack0, 1'b0);
            adv();
        end
        per_req = 1'b0;
        smp();
        chk("drop_ack", per_ack0, 1'b0);
        adv();
        per_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            smp();
            chk("rearm_ack", per_ack0, 1'b0);
            chk("rearm_stall", cpu_stall0, 1'b0);
            adv();
        end
        smp();
        chk("rearm_force_ack", per_ack0, 1'b1);
        chk("rearm_force_stall", cpu_stall0, 1'b1);
        exp_pq.push_back(32'hDEAD_BEEF);
        adv();
        per_req = 1'b0;
        smp();
        chk("rearm_qvalid", per_qvalid0, 1'b1);
        adv();

        // Reset lands on the forced cycle; the wait restarts from zero afterwards.
        per_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk("mid_wait_ack", per_ack0, 1'b0);
            adv();
        end
        reset    = 1'b1;
        cpu_wren = 1'b1;
        smp();
        chk("mid_rst_ack", per_ack0, 1'b0);
        chk("mid_rst_stall", cpu_stall0, 1'b1);
        chk("mid_rst_wen", ram_wEn0, 1'b0);
        adv();
        reset    = 1'b0;
        cpu_wren = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            smp();
            chk("rel_wait_ack", per_ack0, 1'b0);
            chk("rel_wait_stall", cpu_stall0, 1'b0);
            adv();
        end
        smp();
        chk("rel_force_ack", per_ack0, 1'b1);
        chk("rel_force_stall", cpu_stall0, 1'b1);
        exp_pq.push_back(32'hDEAD_BEEF);
        adv();
        per_req = 1'b0;
        cpu_en  = 1'b0;
        smp();
        chk("rel_qvalid", per_qvalid0, 1'b1);
        adv();

        // Reset the cycle after a peripheral read ack: the read data is discarded.
        per_req = 1'b1;
        smp();
        chk("rr_ack", per_ack0, 1'b1);
        adv();
        reset    = 1'b1;
        per_req  = 1'b0;
        cpu_en   = 1'b1;
        cpu_wren = 1'b1;
        smp();
        chk("rr_qvalid", per_qvalid0, 1'b0);
        chk("rr_wen", ram_wEn0, 1'b0);
        chk("rr_stall", cpu_stall0, 1'b1);
        adv();
        reset    = 1'b0;
        cpu_wren = 1'b0;
        smp();
        chk("rr_normal_stall", cpu_stall0, 1'b0);
        chk("rr_after_qvalid", per_qvalid0, 1'b0);
        chk("rr_after_ack", per_ack0, 1'b0);
        adv();

        // STARVE_LIMIT=1 instance: CPU and peripheral alternate under continuous cpu_en.
        idle();
        reset = 1'b1;
        adv();
        reset    = 1'b0;
        cpu_en   = 1'b1;
        cpu_addr = 12'h040;
        per_req  = 1'b1;
        per_addr = 12'h010;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("alt_ack", per_ack1, (i % 2 == 1));
            chk("alt_stall", cpu_stall1, (i % 2 == 1));
            chk("alt_qvalid", per_qvalid1, (i >= 2 && i % 2 == 0));
            if (i >= 2 && i % 2 == 0) chk("alt_q", per_q1, 32'hDEAD_BEEF);
            adv();
        end
        idle();
        smp();
        chk("alt_last_qvalid", per_qvalid1, 1'b1);
        adv();
        adv();

        chk("pq_drained", exp_pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
